// File: rtl/pc_trace_monitor.sv
// Observer for a single-cycle CPU program counter: counts retired/jump PCs and cycles,
// remembers the last jump, and reports done (DONE_ADDR plus settle drain) or a failure cause.
module pc_trace_monitor #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    CNT_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] DONE_ADDR      = 'h0000_006c,
  parameter int                    SETTLE_CYCLES  = 5,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter int                    STUCK_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [1:0]            fail_code,
  output logic [CNT_WIDTH-1:0]  instr_cnt,
  output logic [CNT_WIDTH-1:0]  jump_cnt,
  output logic [CNT_WIDTH-1:0]  cycle_cnt,
  output logic [ADDR_WIDTH-1:0] last_jump_src,
  output logic [ADDR_WIDTH-1:0] last_jump_dst,
  output logic [2:0]            dbg_state
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] FC_TIMEOUT    = 2'b01;
  localparam logic [1:0] FC_STUCK      = 2'b10;
  localparam logic [1:0] FC_MISALIGNED = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_SETTLE = 3'd2,
    S_DONE   = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_fail;
  logic [1:0]            r_fail_code;
  logic [CNT_WIDTH-1:0]  r_instr_cnt;
  logic [CNT_WIDTH-1:0]  r_jump_cnt;
  logic [CNT_WIDTH-1:0]  r_cycle_cnt;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;
  logic [SW-1:0]         r_settle_cnt;
  logic [ADDR_WIDTH-1:0] r_prev_pc;
  logic [ADDR_WIDTH-1:0] r_jump_src;
  logic [ADDR_WIDTH-1:0] r_jump_dst;

  logic w_misaligned;
  logic w_at_done;
  logic w_timeout;
  logic w_same;
  logic w_seq;
  logic w_stuck;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign w_misaligned = (pc_in[1:0] != 2'b00);
  assign w_at_done    = (pc_in == DONE_ADDR);
  assign w_timeout    = (r_cycle_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign w_same       = (pc_in == r_prev_pc);
  assign w_seq        = (pc_in == r_prev_pc + ADDR_WIDTH'(4));
  // The stall counter holds the repeats seen so far; this edge is one more.
  assign w_stuck      = w_same && (r_stall_cnt == CNT_WIDTH'(STUCK_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_fail_code  <= 2'b00;
      r_instr_cnt  <= '0;
      r_jump_cnt   <= '0;
      r_cycle_cnt  <= '0;
      r_stall_cnt  <= '0;
      r_settle_cnt <= '0;
      r_prev_pc    <= '0;
      r_jump_src   <= '0;
      r_jump_dst   <= '0;
    end else if (!en) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state      <= S_RUN;
          r_busy       <= 1'b1;
          r_done       <= 1'b0;
          r_fail       <= 1'b0;
          r_fail_code  <= 2'b00;
          r_instr_cnt  <= '0;
          r_jump_cnt   <= '0;
          r_cycle_cnt  <= '0;
          r_stall_cnt  <= '0;
          r_settle_cnt <= '0;
          r_prev_pc    <= pc_in;
          r_jump_src   <= '0;
          r_jump_dst   <= '0;
        end
        S_RUN: begin
          r_cycle_cnt <= sat_inc(r_cycle_cnt);
          r_prev_pc   <= pc_in;
          if (w_misaligned) begin
            r_state     <= S_FAIL;
            r_busy      <= 1'b0;
            r_fail      <= 1'b1;
            r_fail_code <= FC_MISALIGNED;
          end else if (w_timeout && !w_at_done) begin
            r_state     <= S_FAIL;
            r_busy      <= 1'b0;
            r_fail      <= 1'b1;
            r_fail_code <= FC_TIMEOUT;
          end else begin
            if (w_same) begin
              r_stall_cnt <= sat_inc(r_stall_cnt);
            end else begin
              r_stall_cnt <= '0;
              r_instr_cnt <= sat_inc(r_instr_cnt);
              if (!w_seq) begin
                r_jump_cnt <= sat_inc(r_jump_cnt);
                r_jump_src <= r_prev_pc;
                r_jump_dst <= pc_in;
              end
            end
            // Reaching DONE_ADDR outranks a stuck PC on the same edge.
            if (w_at_done) begin
              r_state      <= S_SETTLE;
              r_settle_cnt <= SW'(1);
            end else if (w_stuck) begin
              r_state     <= S_FAIL;
              r_busy      <= 1'b0;
              r_fail      <= 1'b1;
              r_fail_code <= FC_STUCK;
            end
          end
        end
        S_SETTLE: begin
          r_cycle_cnt <= sat_inc(r_cycle_cnt);
          if (r_settle_cnt == SW'(SETTLE_CYCLES)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_settle_cnt <= r_settle_cnt + SW'(1);
          end
        end
        S_DONE, S_FAIL: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign fail          = r_fail;
  assign fail_code     = r_fail_code;
  assign instr_cnt     = r_instr_cnt;
  assign jump_cnt      = r_jump_cnt;
  assign cycle_cnt     = r_cycle_cnt;
  assign last_jump_src = r_jump_src;
  assign last_jump_dst = r_jump_dst;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Bench for pc_trace_monitor: two instances (default and short timeout) share stimulus and are
// compared every cycle against a behavioural model, plus directed literal expectations.
module tb_pc_trace_monitor;

  localparam int          TMO_A   = 1024;
  localparam int          TMO_B   = 16;
  localparam int          SETTLE  = 5;
  localparam int          STUCK   = 8;
  localparam int          CMAX    = 65535;
  localparam logic [31:0] DONE_PC = 32'h0000_006c;

  localparam int P_IDLE = 0, P_RUN = 1, P_SETTLE = 2, P_DONE = 3, P_FAIL = 4;

  // clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rstn = 1'b0;
  logic        en   = 1'b0;
  logic [31:0] pc   = '0;

  logic        a_busy, a_done, a_fail, b_busy, b_done, b_fail;
  logic [1:0]  a_code, b_code;
  logic [15:0] a_instr, a_jump, a_cycle, b_instr, b_jump, b_cycle;
  logic [31:0] a_src, a_dst, b_src, b_dst;
  logic [2:0]  a_dbg, b_dbg;

  pc_trace_monitor #(.TIMEOUT_CYCLES(TMO_A)) u_dut_a (
    .clk(clk), .rstn(rstn), .en(en), .pc_in(pc),
    .busy(a_busy), .done(a_done), .fail(a_fail), .fail_code(a_code),
    .instr_cnt(a_instr), .jump_cnt(a_jump), .cycle_cnt(a_cycle),
    .last_jump_src(a_src), .last_jump_dst(a_dst), .dbg_state(a_dbg)
  );

  pc_trace_monitor #(.TIMEOUT_CYCLES(TMO_B)) u_dut_b (
    .clk(clk), .rstn(rstn), .en(en), .pc_in(pc),
    .busy(b_busy), .done(b_done), .fail(b_fail), .fail_code(b_code),
    .instr_cnt(b_instr), .jump_cnt(b_jump), .cycle_cnt(b_cycle),
    .last_jump_src(b_src), .last_jump_dst(b_dst), .dbg_state(b_dbg)
  );

  // behavioural model: phase plus "edges left to settle" and "consecutive repeats"
  typedef struct {
    int          phase;
    logic [31:0] prev;
    int          repeats;
    int          settle_left;
    logic        done;
    logic        fail;
    logic [1:0]  code;
    int          instr;
    int          jump;
    int          cycle;
    logic [31:0] src;
    logic [31:0] dst;
  } model_t;

  model_t mdl[2];
  int n_checks = 0;
  int n_err    = 0;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset(input int k);
    mdl[k].phase = P_IDLE; mdl[k].prev = '0; mdl[k].repeats = 0; mdl[k].settle_left = 0;
    mdl[k].done = 1'b0; mdl[k].fail = 1'b0; mdl[k].code = 2'b00;
    mdl[k].instr = 0; mdl[k].jump = 0; mdl[k].cycle = 0; mdl[k].src = '0; mdl[k].dst = '0;
  endtask

  function automatic model_t retire(input model_t m, input logic [31:0] p);
    model_t r;
    r = m;
    if (p == m.prev) begin
      r.repeats = m.repeats + 1;
    end else begin
      r.repeats = 0;
      r.instr = sat(m.instr + 1);
      if (p != m.prev + 32'd4) begin
        r.jump = sat(m.jump + 1);
        r.src  = m.prev;
        r.dst  = p;
      end
    end
    return r;
  endfunction

  task automatic model_step(input int k, input int tmo, input logic e, input logic [31:0] p);
    model_t m;
    int     edges_before;
    m = mdl[k];
    if (!e) begin
      m.phase = P_IDLE;
    end else begin
      case (m.phase)
        P_IDLE: begin
          m.phase = P_RUN; m.prev = p; m.repeats = 0; m.settle_left = 0;
          m.done = 1'b0; m.fail = 1'b0; m.code = 2'b00;
          m.instr = 0; m.jump = 0; m.cycle = 0; m.src = '0; m.dst = '0;
        end
        P_RUN: begin
          edges_before = m.cycle;
          m.cycle = sat(m.cycle + 1);
          if (p[1:0] != 2'b00) begin
            m.phase = P_FAIL; m.fail = 1'b1; m.code = 2'b11;
          end else if (p == DONE_PC) begin
            m = retire(m, p);
            m.phase = P_SETTLE; m.settle_left = SETTLE;
          end else if (edges_before == tmo - 1) begin
            m.phase = P_FAIL; m.fail = 1'b1; m.code = 2'b01;
          end else begin
            m = retire(m, p);
            if (m.repeats >= STUCK) begin
              m.phase = P_FAIL; m.fail = 1'b1; m.code = 2'b10;
            end
          end
          m.prev = p;
        end
        P_SETTLE: begin
          m.cycle = sat(m.cycle + 1);
          m.settle_left = m.settle_left - 1;
          if (m.settle_left == 0) begin
            m.phase = P_DONE; m.done = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
    mdl[k] = m;
  endtask

  always @(negedge rstn) begin
    model_reset(0);
    model_reset(1);
  end

  always @(posedge clk) begin
    if (rstn) begin
      model_step(0, TMO_A, en, pc);
      model_step(1, TMO_B, en, pc);
    end
  end

  // scoreboard helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int k, input logic bsy, input logic dn, input logic fl,
                         input logic [1:0] fc, input logic [15:0] ic, input logic [15:0] jc,
                         input logic [15:0] cc, input logic [31:0] js, input logic [31:0] jd);
    string p;
    logic  exp_busy;
    p = (k == 0) ? "a_" : "b_";
    exp_busy = (mdl[k].phase == P_RUN) || (mdl[k].phase == P_SETTLE);
    chk({p, "busy"},      32'(bsy), 32'(exp_busy));
    chk({p, "done"},      32'(dn),  32'(mdl[k].done));
    chk({p, "fail"},      32'(fl),  32'(mdl[k].fail));
    chk({p, "fail_code"}, 32'(fc),  32'(mdl[k].code));
    chk({p, "instr_cnt"}, 32'(ic),  32'(mdl[k].instr));
    chk({p, "jump_cnt"},  32'(jc),  32'(mdl[k].jump));
    chk({p, "cycle_cnt"}, 32'(cc),  32'(mdl[k].cycle));
    chk({p, "jump_src"},  js,       mdl[k].src);
    chk({p, "jump_dst"},  jd,       mdl[k].dst);
  endtask

  always @(negedge clk) begin
    cmp_dut(0, a_busy, a_done, a_fail, a_code, a_instr, a_jump, a_cycle, a_src, a_dst);
    cmp_dut(1, b_busy, b_done, b_fail, b_code, b_instr, b_jump, b_cycle, b_src, b_dst);
  end

  // driver: called at a negedge; inputs are sampled by the next posedge, returns at the following negedge
  task automatic cyc(input logic e, input logic [31:0] p);
    en = e;
    pc = p;
    @(negedge clk);
  endtask

  task automatic rearm(input logic [31:0] p);
    cyc(1'b0, 32'h0);
    cyc(1'b1, p);
  endtask

  logic [31:0] cur_pc;
  int          r;
  int          len;
  int          hold;

  initial begin
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(a_busy),  32'd0);
    chk("rst_instr", 32'(a_instr), 32'd0);
    chk("rst_src",   a_src,        32'd0);
    rstn = 1'b1;
    cyc(1'b0, 32'h0);

    // straight-line program 0x00..0x6c
    cyc(1'b1, 32'h0);
    for (int a = 4; a <= 32'h6c; a += 4) cyc(1'b1, 32'(a));
    repeat (4) cyc(1'b1, 32'h70);
    chk("t1_done_early", 32'(a_done), 32'd0);
    cyc(1'b1, 32'h70);
    chk("t1_done",  32'(a_done),  32'd1);
    chk("t1_instr", 32'(a_instr), 32'd27);
    chk("t1_jump",  32'(a_jump),  32'd0);
    chk("t1_cycle", 32'(a_cycle), 32'd32);
    chk("t1_fail",  32'(a_fail),  32'd0);
    chk("t1_b_code",  32'(b_code),  32'd1);
    chk("t1_b_cycle", 32'(b_cycle), 32'd16);

    // two jumps, the last straight into DONE_ADDR
    rearm(32'h0);
    cyc(1'b1, 32'h04); cyc(1'b1, 32'h08); cyc(1'b1, 32'h20); cyc(1'b1, 32'h24); cyc(1'b1, 32'h6c);
    repeat (5) cyc(1'b1, 32'h6c);
    chk("t2_jump", 32'(a_jump), 32'd2);
    chk("t2_src",  a_src,       32'h24);
    chk("t2_dst",  a_dst,       32'h6c);
    chk("t2_done", 32'(a_done), 32'd1);

    // stuck at 0x10
    rearm(32'h0);
    cyc(1'b1, 32'h04); cyc(1'b1, 32'h08); cyc(1'b1, 32'h0c); cyc(1'b1, 32'h10);
    repeat (7) cyc(1'b1, 32'h10);
    chk("t3_fail_early", 32'(a_fail), 32'd0);
    cyc(1'b1, 32'h10);
    chk("t3_fail", 32'(a_fail), 32'd1);
    chk("t3_code", 32'(a_code), 32'd2);
    chk("t3_busy", 32'(a_busy), 32'd0);

    // 0x00 <-> 0x04 loop against the short-timeout instance
    rearm(32'h0);
    for (int i = 0; i < 15; i++) cyc(1'b1, (i % 2 == 0) ? 32'h04 : 32'h00);
    chk("t4_fail_early", 32'(b_fail),  32'd0);
    chk("t4_cycle15",    32'(b_cycle), 32'd15);
    cyc(1'b1, 32'h00);
    chk("t4_code",  32'(b_code),  32'd1);
    chk("t4_jump",  32'(b_jump),  32'd7);
    chk("t4_cycle", 32'(b_cycle), 32'd16);
    repeat (3) cyc(1'b1, 32'h04);
    chk("t4_frozen", 32'(b_cycle), 32'd16);

    // misaligned PC in RUN, then the same value during SETTLE
    rearm(32'h0);
    cyc(1'b1, 32'h04);
    cyc(1'b1, 32'h06);
    chk("t5_code", 32'(a_code), 32'd3);
    rearm(32'h0);
    cyc(1'b1, 32'h6c);
    cyc(1'b1, 32'h06);
    repeat (3) cyc(1'b1, 32'h06);
    chk("t5_done_early", 32'(a_done), 32'd0);
    cyc(1'b1, 32'h06);
    chk("t5_done", 32'(a_done), 32'd1);
    chk("t5_fail", 32'(a_fail), 32'd0);

    // asynchronous reset between edges
    rearm(32'h0);
    cyc(1'b1, 32'h04); cyc(1'b1, 32'h08);
    #2 rstn = 1'b0;
    #1;
    chk("t6_busy",  32'(a_busy),  32'd0);
    chk("t6_instr", 32'(a_instr), 32'd0);
    chk("t6_cycle", 32'(a_cycle), 32'd0);
    #1 rstn = 1'b1;
    en = 1'b1;
    pc = 32'h10;
    @(negedge clk);
    chk("t6_rearm_busy", 32'(a_busy),  32'd1);
    chk("t6_rearm_cyc",  32'(a_cycle), 32'd0);
    cyc(1'b1, 32'h14);
    chk("t6_instr1", 32'(a_instr), 32'd1);
    chk("t6_cycle1", 32'(a_cycle), 32'd1);

    // randomized programs
    for (int s = 0; s < 60; s++) begin
      cur_pc = 32'($urandom_range(0, 31)) << 2;
      rearm(cur_pc);
      len = $urandom_range(10, 60);
      for (int c = 0; c < len; c++) begin
        r = $urandom_range(0, 99);
        if (r < 55) begin
          cur_pc = cur_pc + 32'd4;
          cyc(1'b1, cur_pc);
        end else if (r < 70) begin
          hold = $urandom_range(1, 9);
          repeat (hold) cyc(1'b1, cur_pc);
        end else if (r < 85) begin
          cur_pc = 32'($urandom_range(0, 31)) << 2;
          cyc(1'b1, cur_pc);
        end else if (r < 90) begin
          cur_pc = DONE_PC;
          cyc(1'b1, cur_pc);
        end else if (r < 93) begin
          cyc(1'b1, cur_pc + 32'($urandom_range(1, 3)));
        end else if (r < 95) begin
          cyc(1'b0, cur_pc);
        end else begin
          cur_pc = {$urandom()} & 32'hffff_fffc;
          cyc(1'b1, cur_pc);
        end
      end
    end

    cyc(1'b0, 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_trace_monitor.md
Name: pc_trace_monitor

Overview:
- Synthesizable observer sitting directly downstream of single_cycle_cpu; consumes the CPU's addr_out (current PC) every cycle.
- Counts sequential instructions, control-flow transfers and cycles; records the last jump.
- Flags run completion (PC reaches DONE_ADDR, then SETTLE_CYCLES drain) or failure (timeout, stuck PC, misaligned PC).
- Replaces the bench-side wait/settle loop; the same pass/fail result is available in gate-level simulation and on FPGA.

Parameters:
ADDR_WIDTH, 32, width of pc_in and jump address outputs
CNT_WIDTH, 16, width of all counters
DONE_ADDR, 32'h0000_006c, PC value that marks end of program
SETTLE_CYCLES, 5, cycles to wait after DONE_ADDR before asserting done (must be >= 1)
TIMEOUT_CYCLES, 1024, RUN+SETTLE cycle budget before timeout
STUCK_CYCLES, 8, consecutive unchanged-PC cycles that declare stuck (must be >= 2)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
en  in  1  level: 1 = monitor armed; 0 = return to IDLE
pc_in  in  ADDR_WIDTH  CPU PC (addr_out)
busy  out  1  state is RUN or SETTLE
done  out  1  program completed (sticky until en=0)
fail  out  1  any failure (sticky until en=0)
fail_code  out  2  00 none, 01 timeout, 10 stuck, 11 misaligned
instr_cnt  out  CNT_WIDTH  PCs retired (sequential + jumps)
jump_cnt  out  CNT_WIDTH  non-sequential PC changes
cycle_cnt  out  CNT_WIDTH  cycles spent in RUN and SETTLE
last_jump_src  out  ADDR_WIDTH  PC before the most recent jump
last_jump_dst  out  ADDR_WIDTH  PC after the most recent jump

Behaviour:
- Reset (rstn=0, asynchronous): state IDLE; all outputs, prev_pc, stall_cnt and settle_cnt are 0.
- All outputs are registered; they update at the rising edge.
- States: IDLE, RUN, SETTLE, DONE, FAIL.
- IDLE, en=1: prev_pc<=pc_in; clear all counters, flags and last_jump_*; go to RUN.
- IDLE, en=0: hold.
- Any state, en=0: go to IDLE next edge. Counters and flags hold their values until re-arm.
- RUN, each edge, in priority order:
  1. pc_in[1:0]!=0: FAIL, fail_code=11.
  2. pc_in==DONE_ADDR: go to SETTLE; settle_cnt<=1; instr_cnt updates per rules 4-6 for this edge.
  3. cycle_cnt==TIMEOUT_CYCLES-1: FAIL, fail_code=01.
  4. pc_in==prev_pc+4 (mod 2^ADDR_WIDTH): instr_cnt++; stall_cnt<=0.
  5. pc_in!=prev_pc and not rule 4: instr_cnt++; jump_cnt++; last_jump_src<=prev_pc; last_jump_dst<=pc_in; stall_cnt<=0.
  6. pc_in==prev_pc: stall_cnt++. When stall_cnt reaches STUCK_CYCLES-1, go to FAIL, fail_code=10.
  7. Every RUN edge: cycle_cnt++ and prev_pc<=pc_in.
- SETTLE: cycle_cnt++ each edge; instr_cnt, jump_cnt and last_jump_* are frozen; pc_in is ignored, including misalignment.
  - When settle_cnt==SETTLE_CYCLES, go to DONE with done=1. done therefore rises on the SETTLE_CYCLES-th edge after the edge that sampled DONE_ADDR.
  - Otherwise settle_cnt++.
  - A timeout during SETTLE is ignored; DONE_ADDR wins.
- DONE and FAIL: terminal. All counters are frozen. done and fail are mutually exclusive.
- Counter width: every counter saturates at all-ones and never wraps.
- busy=1 only in RUN or SETTLE.
- pc_in is synchronous to clk; no synchronizer is required.

Test Plan:
1. Reset, en=1 with pc 0x00, then pc 0x04, 0x08, ..., 0x6c (one per clk).
   -> done rises 5 edges after 0x6c is sampled; instr_cnt=27, jump_cnt=0, fail=0.
2. pc sequence 0x00, 0x04, 0x08, 0x20, 0x24, then 0x6c.
   -> jump_cnt=2, last_jump_src=0x24, last_jump_dst=0x6c, done=1.
3. pc held at 0x10 after reaching it.
   -> fail=1, fail_code=10, on the 7th edge after the first repeat; busy=0.
4. TIMEOUT_CYCLES=16, PC loops 0x00 -> 0x04 -> 0x00 forever.
   -> fail_code=01 when cycle_cnt=15; jump_cnt=7, and cycle_cnt freezes at 16.
5. pc 0x06 sampled in RUN -> fail_code=11 next edge. Same value sampled in SETTLE -> ignored, done still rises.
6. rstn pulsed low mid-RUN (asynchronously, between edges).
   -> all outputs 0 immediately; with en=1, re-arms on the next edge after rstn=1 and counts restart from 0.
